// File: rtl/guess_pkg.sv
// Shared types for the two-player hex guessing game.
// State enum, segment codes, 16-bit value type, digit helpers.
package guess_pkg;

    typedef enum logic [2:0] {
        ST_SETUP,
        ST_HANDOFF,
        ST_GUESS,
        ST_RESULT,
        ST_WON
`ifdef GUESS_LIMIT_EN
        , ST_LOST
`endif
    } state_e;

    typedef logic [15:0] val16_t;

    // Active-low {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_H     = 7'b1001000;
    localparam logic [6:0] SEG_I     = 7'b1001111;
    localparam logic [6:0] SEG_L     = 7'b1110001;
    localparam logic [6:0] SEG_O     = 7'b0000001;
    localparam logic [6:0] SEG_P     = 7'b0011000;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Lowest set button index wins when several fire together.
    function automatic logic [1:0] low_idx(logic [3:0] b);
        if (b[0])      return 2'd0;
        else if (b[1]) return 2'd1;
        else if (b[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic val16_t set_digit(val16_t v, logic [1:0] idx,
                                         logic [3:0] d);
        val16_t r;
        r = v;
        r[{idx, 2'b00} +: 4] = d;
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex.sv
// Hex digit to active-low seven-segment decoder.
// Ports: i_hex (4-bit value), o_seg ({a..g}, active-low).
module seg7_hex (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = 7'b1111111;
        case (i_hex)
            4'h0: o_seg = 7'b0000001;
            4'h1: o_seg = 7'b1001111;
            4'h2: o_seg = 7'b0010010;
            4'h3: o_seg = 7'b0000110;
            4'h4: o_seg = 7'b1001100;
            4'h5: o_seg = 7'b0100100;
            4'h6: o_seg = 7'b0100000;
            4'h7: o_seg = 7'b0001111;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0000100;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b1100000;
            4'hC: o_seg = 7'b0110001;
            4'hD: o_seg = 7'b1000010;
            4'hE: o_seg = 7'b0110000;
            4'hF: o_seg = 7'b0111000;
            default: o_seg = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/guess_game_ctrl.sv
// Two-player hex guessing game: P1 sets a secret, P2 guesses with hints.
// Ports: clk, rst (async high), btn/bcd digit load, submit switch,
//   seg_d3..seg_d0 (active-low), led, guesses, won.
// Optional macro GUESS_LIMIT_EN adds MAX_GUESSES limit and LOST state.
module guess_game_ctrl #(
    parameter int CELEB_DIV = 25000
`ifdef GUESS_LIMIT_EN
    , parameter int MAX_GUESSES = 8
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [3:0] bcd,
    input  logic       submit,
    output logic [6:0] seg_d3,
    output logic [6:0] seg_d2,
    output logic [6:0] seg_d1,
    output logic [6:0] seg_d0,
    output logic [7:0] led,
    output logic [3:0] guesses,
    output logic       won
);
    import guess_pkg::*;

    localparam int DIV_W = (CELEB_DIV > 1) ? $clog2(CELEB_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CELEB_DIV - 1);

    state_e           r_state;
    val16_t           r_secret;
    val16_t           r_guess;
    logic [3:0]       r_guesses;
    logic             r_sub_q;
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_led;
    logic             r_won;
    logic             r_hi;

    logic       w_edge;
    logic       w_load;
    logic [1:0] w_idx;
    logic [3:0] w_cnt_nx;
    val16_t     w_val;
    logic [6:0] w_hx [4];

    assign w_edge   = submit & ~r_sub_q;
    assign w_load   = |btn;
    assign w_idx    = low_idx(btn);
    assign w_cnt_nx = (r_guesses == 4'hF) ? 4'hF : r_guesses + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_SETUP;
            r_secret  <= '0;
            r_guess   <= '0;
            r_guesses <= '0;
            r_sub_q   <= 1'b0;
            r_div     <= '0;
            r_led     <= 8'h00;
            r_won     <= 1'b0;
            r_hi      <= 1'b0;
        end else begin
            // Tracks submit in every state, so a held switch never
            // re-triggers after a state change.
            r_sub_q <= submit;
            unique case (r_state)
                ST_SETUP: begin
                    if (w_edge) begin
                        r_state <= ST_HANDOFF;
                        r_guess <= '0;
                    end else if (w_load) begin
                        r_secret <= set_digit(r_secret, w_idx, bcd);
                    end
                end
                ST_HANDOFF: begin
                    if (w_load) begin
                        r_guess <= set_digit(r_guess, w_idx, bcd);
                        r_state <= ST_GUESS;
                    end
                end
                ST_GUESS: begin
                    if (w_edge) begin
                        r_guesses <= w_cnt_nx;
                        if (r_guess == r_secret) begin
                            r_state <= ST_WON;
                            r_won   <= 1'b1;
                        end
`ifdef GUESS_LIMIT_EN
                        else if (w_cnt_nx == 4'(MAX_GUESSES)) begin
                            r_state <= ST_LOST;
                            r_led   <= 8'hFF;
                        end
`endif
                        else begin
                            r_state <= ST_RESULT;
                            r_hi    <= (r_guess > r_secret);
                        end
                    end else if (w_load) begin
                        r_guess <= set_digit(r_guess, w_idx, bcd);
                    end
                end
                ST_RESULT: begin
                    if (w_load) begin
                        r_guess <= set_digit(r_guess, w_idx, bcd);
                        r_state <= ST_GUESS;
                    end
                end
                ST_WON: begin
                    if (r_div == DIV_TC) begin
                        r_div <= '0;
                        r_led <= ~r_led;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
`ifdef GUESS_LIMIT_EN
                ST_LOST: begin
                    r_led <= 8'hFF;
                end
`endif
                default: r_state <= ST_SETUP;
            endcase
        end
    end

    always_comb begin
        w_val = {12'h000, r_guesses};
        if (r_state == ST_SETUP)
            w_val = r_secret;
        else if (r_state == ST_GUESS)
            w_val = r_guess;
    end

    for (genvar i = 0; i < 4; i++) begin : g_hex
        seg7_hex u_hex (
            .i_hex (w_val[i*4 +: 4]),
            .o_seg (w_hx[i])
        );
    end

    always_comb begin
        seg_d3 = SEG_BLANK;
        seg_d2 = SEG_BLANK;
        seg_d1 = SEG_BLANK;
        seg_d0 = SEG_BLANK;
        case (r_state)
            ST_SETUP, ST_GUESS: begin
                seg_d3 = w_hx[3];
                seg_d2 = w_hx[2];
                seg_d1 = w_hx[1];
                seg_d0 = w_hx[0];
            end
            ST_HANDOFF: begin
                seg_d3 = SEG_P;
                seg_d2 = SEG_2;
            end
            ST_RESULT: begin
                seg_d3 = r_hi ? SEG_H : SEG_L;
                seg_d2 = r_hi ? SEG_I : SEG_O;
                seg_d0 = w_hx[0];
            end
            ST_WON: begin
                seg_d0 = w_hx[0];
            end
`ifdef GUESS_LIMIT_EN
            ST_LOST: begin
                seg_d3 = SEG_DASH;
                seg_d2 = SEG_DASH;
                seg_d1 = SEG_DASH;
                seg_d0 = SEG_DASH;
            end
`endif
            default: ;
        endcase
    end

    assign led     = r_led;
    assign guesses = r_guesses;
    assign won     = r_won;

endmodule

// File: doc/guess_game_ctrl.md
GUESS_GAME_CTRL -- requirements
Module: guess_game_ctrl

Interface
REQ-001 Parameter CELEB_DIV, default 25000, clock cycles between LED toggles in WON; legal range >= 1.
REQ-002 Parameter MAX_GUESSES, default 8, guess limit used only when GUESS_LIMIT_EN is defined; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn  input  4  digit-load pulses, already debounced, one cycle wide; bit i loads digit i.
REQ-006 bcd  input  4  hex digit value, 0x0..0xF, sampled on a btn pulse.
REQ-007 submit  input  1  level-sensitive switch; only its rising edge acts.
REQ-008 seg_d3..seg_d0  output  7 each  active-low segments {a,b,c,d,e,f,g}; d3 is the leftmost digit.
REQ-009 led  output  8  celebration LEDs.
REQ-010 guesses  output  4  count of submitted guesses, saturating at 15.
REQ-011 won  output  1  high while in WON.

Function
REQ-012 States SHALL be SETUP, HANDOFF, GUESS, RESULT and WON, plus LOST only when GUESS_LIMIT_EN is defined.
REQ-013 Submit edge: sub_q registers submit; edge = submit & ~sub_q; the state changes on the same clk edge that samples the edge, so outputs update one cycle after submit first reads high.
REQ-014 Digit load: on btn pulse in SETUP, HANDOFF, GUESS or RESULT, the active entry register digit i SHALL take bcd; if several bits are set, the lowest index wins.
REQ-015 SETUP: btn loads the secret register; the display shows secret digits in hex; submit edge moves to HANDOFF.
REQ-016 HANDOFF: the guess register is cleared to 0x0000; the display shows "P2  "; submit is ignored; a btn pulse loads the guess digit and moves to GUESS.
REQ-017 GUESS: the display shows guess digits in hex; on submit edge, guesses increments (saturating at 15) and the 16-bit unsigned values {d3..d0} are compared.
REQ-018 Compare outcomes: guess == secret moves to WON; guess < secret moves to RESULT showing "LO"; guess > secret moves to RESULT showing "HI".
REQ-019 RESULT: seg_d3/seg_d2 show the letters, seg_d1 is blank, and seg_d0 shows guesses in hex; submit is ignored; a btn pulse loads the digit (other digits retained) and returns to GUESS.
REQ-020 WON: seg_d3..seg_d1 are blank and seg_d0 shows guesses; won=1; a divider counts 0..CELEB_DIV-1, and at terminal count led inverts (starting at 0x00) and the divider wraps to 0.
REQ-021 WON and LOST are exited only by rst; btn and submit are ignored there.
REQ-022 A submit held high across state changes SHALL NOT act again until it goes low and returns high.
REQ-023 Segment codes: H=1001000, I=1001111, L=1110001, O=0000001, P=0011000, 2=0010010, blank=1111111, dash=1111110.

Reset
REQ-024 rst SHALL force state=SETUP, secret=0, guess=0, guesses=0, sub_q=0, divider=0, led=0x00, won=0, and all segments showing "0000" (SETUP display).
REQ-025 rst asserted mid-game, including in WON, SHALL abandon the game immediately with no pending outputs.

Configuration
REQ-026 With GUESS_LIMIT_EN defined, a non-matching submit that makes guesses == MAX_GUESSES SHALL enter LOST, all digits show dash, and led=0xFF steady.
REQ-027 Without GUESS_LIMIT_EN, LOST and MAX_GUESSES logic SHALL be absent, guessing is unlimited, and guesses saturates at 15.

Structure
REQ-028 Package guess_pkg SHALL hold the state enum, the segment-code constants, and the 16-bit value typedef.
REQ-029 Sub-module seg7_hex (4-bit in, 7-bit active-low out) SHALL be instantiated for hex digit display.

Verification
REQ-030 Reset then btn[3..0] with bcd 1,2,3,4 -> segments "1234"; submit edge -> "P2  ".
REQ-031 Secret 0x1234, guess 0x1000 submitted -> "LO 1", guesses=1; guess 0x2000 -> "HI 2".
REQ-032 Guess 0x1234 on the third submit -> WON, won=1, seg_d0 shows 3; with CELEB_DIV=4, led toggles 0x00->0xFF->0x00 every 4 cycles.
REQ-033 Submit held high through the SETUP->HANDOFF->GUESS transitions -> no compare until submit toggles low then high.
REQ-034 btn=4'b0110 with bcd=7 in GUESS -> only digit1 becomes 7.
REQ-035 GUESS_LIMIT_EN with MAX_GUESSES=2 and two wrong guesses -> LOST, "----", led=0xFF; rst -> SETUP "0000", led=0x00.
